sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock synchronous FIFO buffering fixed-width data words between a producer and a consumer in the same clock domain, such as the per-port queues of the cross-bar. The producer writes with a `push` strobe and the consumer reads with a `pop` strobe. Registered `empty`/`full` flags provide flow control. Data leaves in strict arrival order.

## Interface
- `DWIDTH`, default 32: data word width in bits.
- `DEPTH`, default 8: number of storage entries; must be a power of two and at least 2.
- `aclk`  input  1: clock; all logic on the rising edge.
- `aresetn`  input  1: reset.
  - Asynchronous assert, active-low.
  - Deassertion is sampled on `aclk`.
- `push_data`  input  DWIDTH: write data, sampled on a rising edge where `push` is accepted.
- `push`  input  1: write request, one word per cycle while high.
- `pop`  input  1: read request, one word per cycle while high.
- `pop_data`  output  DWIDTH: registered read data.
- `empty`  output  1: no words stored.
- `full`  output  1: DEPTH words stored.

## Operation
- Storage:
  - Memory array of DEPTH x DWIDTH.
  - Write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter of log2(DEPTH)+1 bits, range 0..DEPTH.
- Accepted push is `push && !full`, using the flag value before the edge.
  - Writes `push_data` at the write pointer, then increments the write pointer.
- Accepted pop is `pop && !empty`, using the flag value before the edge.
  - Loads `pop_data` from the read-pointer entry, then increments the read pointer.
- Push while full: ignored. Data is dropped; pointers, count and memory are unchanged.
- Pop while empty: ignored. `pop_data` holds its last value; pointers and count are unchanged.
- Occupancy counter update per edge:
  - Push accepted, pop not accepted: +1.
  - Pop accepted, push not accepted: -1.
  - Both accepted: unchanged.
- Push and pop in the same cycle:
  - When neither full nor empty, both are accepted and the count is unchanged.
  - When empty, only the push is accepted. There is no fall-through; the popped word is not the one being pushed.
  - When full, only the pop is accepted and the count becomes DEPTH-1.
- `empty` is registered: 1 when the next count is 0.
- `full` is registered: 1 when the next count is DEPTH.
- `pop_data` holds its value on every cycle without an accepted pop.
- Reset, including mid-operation:
  - Pointers and count go to 0, `empty`=1, `full`=0, `pop_data`=0.
  - Stored contents are discarded logically; the memory array itself is not cleared.

## Timing
- Reset values: `pop_data`=0, `empty`=1, `full`=0.
- Push to flags:
  - A push accepted at edge N deasserts `empty` after edge N, visible in cycle N+1.
  - That word is poppable from cycle N+1.
- Pop latency: `pop` high at edge N (accepted) gives the word on `pop_data` after edge N, valid in cycle N+1.
- `full` asserts after the edge that stores the DEPTH-th word.
- `full` deasserts after the first accepted pop from full.
- Throughput:
  - One push and one pop per cycle.
  - Continuous streaming at full rate is sustainable when neither full nor empty.
- No combinational path from any input to any output.

## Test plan
- Reset:
  - Hold `aresetn`=0 for 100 cycles -> `empty`=1, `full`=0, `pop_data`=0.
  - Release reset -> outputs unchanged.
- Ordered transfer:
  - Six single-cycle pushes of 1..6, each followed by an idle cycle -> `empty`=0 after the first push, `full` stays 0.
  - Then six single-cycle pops, each followed by an idle cycle -> `pop_data` = 1,2,3,4,5,6 in order, each valid the cycle after its pop.
  - `empty`=1 after the sixth pop.
- Fill and overflow:
  - Push 8 words 0xA0..0xA7 -> `full`=1 after the 8th.
  - A 9th push of 0xFF is ignored.
  - Eight pops return 0xA0..0xA7, with `full`=0 after the first pop.
- Underflow: pop while empty -> `pop_data` keeps its previous value and `empty` stays 1.
- Simultaneous push and pop:
  - With 3 words stored, push and pop together for 20 cycles -> count stays 3 and data order is preserved across pointer wrap.
  - At empty, a simultaneous push and pop -> push only, `empty`=0.
  - At full, a simultaneous push and pop -> pop only, `full`=0.
- Reset mid-operation:
  - Assert `aresetn`=0 asynchronously with 5 words stored -> `empty`=1, `full`=0, `pop_data`=0 immediately.
  - After reset, new pushes are read back correctly.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered empty/full flags and registered read data.
// Occupancy counter drives the flags so both are available straight from flops.
module sync_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              push,
    input  logic              pop,
    output logic [DWIDTH-1:0] pop_data,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_nxt;
    logic              push_ok;
    logic              pop_ok;

    // Acceptance uses the registered flags, so a push at empty never falls through.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            pop_data <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                pop_data <= mem[rd_ptr];
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == FULL_CNT);
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DWIDTH=32, DEPTH=8).
module tb_sync_fifo;

    logic        aclk;
    logic        aresetn;
    logic [31:0] push_data;
    logic        push;
    logic        pop;
    logic [31:0] pop_data;
    logic        empty;
    logic        full;

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo #(.DWIDTH(32), .DEPTH(8)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push_data (push_data),
        .push      (push),
        .pop       (pop),
        .pop_data  (pop_data),
        .empty     (empty),
        .full      (full)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Drive one cycle of stimulus from a negedge; return at the next negedge.
    task automatic step(input logic p, input logic [31:0] d, input logic q);
        push      = p;
        push_data = d;
        pop       = q;
        @(posedge aclk);
        @(negedge aclk);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (100) @(negedge aclk);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
        n_checks++; if (pop_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", pop_data); end
        aresetn = 1'b1;
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL release_empty got %b exp 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL release_full got %b exp 0", full); end
        n_checks++; if (pop_data !== 32'h0) begin n_fail++; $display("FAIL release_data got %h exp 0", pop_data); end
    endtask

    task automatic test_ordered;
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 32'(i), 1'b0);
            n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL ord_push_empty i=%0d got %b exp 0", i, empty); end
            n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL ord_push_full i=%0d got %b exp 0", i, full); end
            step(1'b0, 32'h0, 1'b0);
        end
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 32'h0, 1'b1);
            n_checks++; if (pop_data !== 32'(i)) begin n_fail++; $display("FAIL ord_pop i=%0d got %h exp %h", i, pop_data, 32'(i)); end
            step(1'b0, 32'h0, 1'b0);
            n_checks++; if (pop_data !== 32'(i)) begin n_fail++; $display("FAIL ord_hold i=%0d got %h exp %h", i, pop_data, 32'(i)); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ord_end_empty got %b exp 1", empty); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'hA0 + 32'(i), 1'b0);
            n_checks++; if (full !== (i == 7)) begin n_fail++; $display("FAIL fill_full i=%0d got %b exp %b", i, full, (i == 7)); end
        end
        step(1'b1, 32'hFF, 1'b0);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b exp 1", full); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 1'b1);
            n_checks++; if (pop_data !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL fill_pop i=%0d got %h exp %h", i, pop_data, 32'hA0 + 32'(i)); end
            n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_pop_full i=%0d got %b exp 0", i, full); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_end_empty got %b exp 1", empty); end
    endtask

    task automatic test_underflow;
        step(1'b0, 32'h0, 1'b1);
        n_checks++; if (pop_data !== 32'hA7) begin n_fail++; $display("FAIL udf_data got %h exp a7", pop_data); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL udf_empty got %b exp 1", empty); end
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < 3; i++) step(1'b1, 32'h10 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h13 + 32'(i), 1'b1);
            n_checks++; if (pop_data !== 32'h10 + 32'(i)) begin n_fail++; $display("FAIL sim_data i=%0d got %h exp %h", i, pop_data, 32'h10 + 32'(i)); end
            n_checks++; if ({empty, full} !== 2'b00) begin n_fail++; $display("FAIL sim_flags i=%0d got %b exp 00", i, {empty, full}); end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1);
            n_checks++; if (pop_data !== 32'h24 + 32'(i)) begin n_fail++; $display("FAIL sim_drain i=%0d got %h exp %h", i, pop_data, 32'h24 + 32'(i)); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sim_drain_empty got %b exp 1", empty); end
        // Push+pop at empty: only the push lands.
        step(1'b1, 32'h55, 1'b1);
        n_checks++; if (pop_data !== 32'h26) begin n_fail++; $display("FAIL pe_data got %h exp 26", pop_data); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL pe_empty got %b exp 0", empty); end
        step(1'b0, 32'h0, 1'b1);
        n_checks++; if (pop_data !== 32'h55) begin n_fail++; $display("FAIL pe_pop got %h exp 55", pop_data); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pe_pop_empty got %b exp 1", empty); end
        // Push+pop at full: only the pop lands.
        for (int i = 0; i < 8; i++) step(1'b1, 32'h60 + 32'(i), 1'b0);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL pf_full got %b exp 1", full); end
        step(1'b1, 32'h77, 1'b1);
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL pf_full_after got %b exp 0", full); end
        n_checks++; if (pop_data !== 32'h60) begin n_fail++; $display("FAIL pf_data got %h exp 60", pop_data); end
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 32'h0, 1'b1);
            n_checks++; if (pop_data !== 32'h60 + 32'(i)) begin n_fail++; $display("FAIL pf_drain i=%0d got %h exp %h", i, pop_data, 32'h60 + 32'(i)); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pf_drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) step(1'b1, 32'h80 + 32'(i), 1'b0);
        #2 aresetn = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty got %b exp 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL mid_full got %b exp 0", full); end
        n_checks++; if (pop_data !== 32'h0) begin n_fail++; $display("FAIL mid_data got %h exp 0", pop_data); end
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        step(1'b1, 32'h90, 1'b0);
        step(1'b1, 32'h91, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        n_checks++; if (pop_data !== 32'h90) begin n_fail++; $display("FAIL mid_pop0 got %h exp 90", pop_data); end
        step(1'b0, 32'h0, 1'b1);
        n_checks++; if (pop_data !== 32'h91) begin n_fail++; $display("FAIL mid_pop1 got %h exp 91", pop_data); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_end_empty got %b exp 1", empty); end
    endtask

    initial begin
        aresetn   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        @(negedge aclk);
        test_reset;
        test_ordered;
        test_fill;
        test_underflow;
        test_simultaneous;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
